// File: rtl/alu_control_seq.sv
// ALU control decoder with a valid/ready request port and a registered, back-pressured result stage.
// Undefined encodings are flagged. Mult/div requests hold busy for MULDIV_CYCLES-1 cycles before the result appears.
module alu_control_seq #(
  parameter int unsigned FUNCT_W       = 6,
  parameter int unsigned CTRL_W        = 4,
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter logic [3:0]  ILLEGAL_CODE  = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALUoperation,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ALUcontrol,
  output logic               illegal,
  output logic               busy
);

  localparam int unsigned CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FULL = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CTRL_W-1:0]  ctrl_r;
  logic               illegal_r;
  logic               accept_s;
  logic [5:0]         dec_s;
  logic               funct_unused_s;

  // Packed result: {muldiv, illegal, code[3:0]}; only funct[5:0] participates.
  function automatic logic [5:0] decode(input logic [1:0] op, input logic [5:0] f);
    logic [5:0] d;
    case (op)
      2'b00: d = 6'b00_0010;
      2'b01: d = 6'b00_0110;
      2'b10: begin
        case (f)
          6'b100000: d = 6'b00_0010;
          6'b100010: d = 6'b00_0110;
          6'b100100: d = 6'b00_0000;
          6'b100101: d = 6'b00_0001;
          6'b100110: d = 6'b00_0011;
          6'b100111: d = 6'b00_1100;
          6'b101010: d = 6'b00_0111;
          6'b011000: d = 6'b10_1000;
          6'b011010: d = 6'b10_1001;
          default:   d = {2'b01, ILLEGAL_CODE};
        endcase
      end
      default: d = {2'b01, ILLEGAL_CODE};
    endcase
    return d;
  endfunction

  assign funct_unused_s = ^funct;
  assign dec_s          = decode(ALUoperation, funct[5:0]);
  assign accept_s       = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Result and mult/div countdown registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_r    <= {CTRL_W{1'b0}};
      illegal_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      ctrl_r    <= CTRL_W'(dec_s[3:0]);
      illegal_r <= dec_s[4];
      cnt_r     <= dec_s[5] ? CNT_W'(MULDIV_CYCLES - 1) : {CNT_W{1'b0}};
    end else if (state_r == ST_BUSY && cnt_r != {CNT_W{1'b0}}) begin
      cnt_r     <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r     <= cnt_r;
    end
  end

  // Next-state logic; an accept can refill FULL on the same edge it is drained.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = dec_s[5] ? ST_BUSY : ST_FULL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_next_s = dec_s[5] ? ST_BUSY : ST_FULL;
        end else if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    out_valid  = (state_r == ST_FULL);
    busy       = (state_r == ST_BUSY);
    in_ready   = (state_r != ST_BUSY) && ((state_r != ST_FULL) || out_ready);
    ALUcontrol = ctrl_r;
    illegal    = illegal_r;
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed plus random bench for alu_control_seq, checked cycle by cycle against a transaction-level model.
module tb_alu_control_seq;

  localparam int MULDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUoperation;
  logic [7:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALUcontrol;
  logic       illegal;
  logic       busy;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Model state: output slot contents and cycles left on a mult/div.
  bit       m_valid;
  bit       m_busy;
  bit       m_ill;
  bit [3:0] m_ctrl;
  int       m_left;

  alu_control_seq #(
    .FUNCT_W(8), .CTRL_W(4), .MULDIV_CYCLES(MULDIV), .ILLEGAL_CODE(4'b1111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUoperation(ALUoperation), .funct(funct), .out_valid(out_valid),
    .out_ready(out_ready), .ALUcontrol(ALUcontrol), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at step %0d", tag, obs, exp, n_vec);
    end
  endtask

  // Instruction table lookup: R-type functions and their control codes.
  task automatic ref_decode(input logic [1:0] op, input logic [5:0] f,
                            output bit [3:0] code, output bit ill, output bit md);
    int fn [9]   = '{32, 34, 36, 37, 38, 39, 42, 24, 26};
    int cd [9]   = '{2, 6, 0, 1, 3, 12, 7, 8, 9};
    code = 4'd15; ill = 1'b1; md = 1'b0;
    if (op == 2'd0) begin
      code = 4'd2; ill = 1'b0;
    end else if (op == 2'd1) begin
      code = 4'd6; ill = 1'b0;
    end else if (op == 2'd2) begin
      for (int i = 0; i < 9; i++) begin
        if (int'(f) == fn[i]) begin
          code = 4'(cd[i]); ill = 1'b0; md = (i >= 7);
        end
      end
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic [1:0] op,
                      input logic [7:0] f, input logic ordy);
    bit       exp_rdy;
    bit       acc;
    bit [3:0] code;
    bit       ill;
    bit       md;
    @(negedge clk);
    rst_n = rn; in_valid = v; ALUoperation = op; funct = f; out_ready = ordy;
    #1;
    exp_rdy = !m_busy && (!m_valid || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    ref_decode(op, f[5:0], code, ill, md);
    @(posedge clk);
    if (!rn) begin
      m_valid = 1'b0; m_busy = 1'b0; m_ill = 1'b0; m_ctrl = 4'd0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_valid = 1'b1;
      end
    end else if (acc) begin
      m_ctrl = code; m_ill = ill;
      if (md) begin
        m_busy = 1'b1; m_valid = 1'b0; m_left = MULDIV - 1;
      end else begin
        m_valid = 1'b1;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("ALUcontrol", {28'd0, ALUcontrol}, {28'd0, m_ctrl});
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    n_vec++;
  endtask

  initial begin
    logic [7:0] picks [12];
    logic [7:0] sweep [7];
    logic [7:0] fr;
    picks = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h2A, 8'h18, 8'h1A, 8'h00, 8'h19, 8'h3F};
    sweep = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h2A};

    rst_n = 1'b0; in_valid = 1'b0; ALUoperation = 2'd0; funct = 8'd0; out_ready = 1'b0;
    @(posedge clk);
    m_valid = 1'b0; m_busy = 1'b0; m_ill = 1'b0; m_ctrl = 4'd0; m_left = 0;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
    end
    step(1'b1, 1'b0, 2'd0, 8'd0, 1'b1);

    // Single-cycle sweep.
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 2'd1, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 2'd2, sweep[i], 1'b1);
    step(1'b1, 1'b0, 2'd2, 8'h22, 1'b1);

    // Back-pressure.
    step(1'b1, 1'b1, 2'd2, 8'h20, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h22, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h22, 1'b1);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);

    // Mult, then a div stalled behind it.
    step(1'b1, 1'b1, 2'd2, 8'h18, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd2, 8'h1A, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd2, 8'h1A, 1'b1);

    // Illegal encodings, with upper funct bits set on one, then a legal add.
    step(1'b1, 1'b1, 2'd3, 8'h20, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'h00, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'hD9, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'hE0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1);

    // Reset in the middle of a div.
    step(1'b1, 1'b1, 2'd2, 8'h1A, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd2, 8'h1A, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      fr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 11)];
      fr[7:6] = 2'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), 2'($urandom), fr,
           ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
